// File: rtl/fill_rect_data_gen_pkg.sv
// Shared types and defaults for the fill-rect pixel generator: FSM states,
// the RGB444 pixel payload, and the linear framebuffer address helper.
package fill_rect_data_gen_pkg;

  localparam int unsigned DEF_SCREEN_WIDTH = 640;
  localparam int unsigned DEF_ADDR_WIDTH   = 19;
  localparam int unsigned COORD_W          = 16;
  localparam int unsigned CHAN_W           = 4;
  localparam int unsigned PIX_W            = 3 * CHAN_W;
  localparam int unsigned BASE_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb444_t;

  // y*screen_width + x, evaluated at full 32-bit width before any truncation
  function automatic logic [BASE_W-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input int unsigned        sw);
    return BASE_W'(y) * BASE_W'(sw) + BASE_W'(x);
  endfunction

endpackage

// File: rtl/fill_rect_raster_counter.sv
// Column/row walker for one rectangle: holds the current row base, flags the
// final pixel and presents the address of the pixel that follows the current one.
module fill_rect_raster_counter
  import fill_rect_data_gen_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  i_load,
  input  logic [BASE_W-1:0]     i_base,
  input  logic [COORD_W-1:0]    i_wid,
  input  logic [COORD_W-1:0]    i_hgt,
  input  logic                  i_adv,
  output logic                  o_last_c,
  output logic [ADDR_WIDTH-1:0] o_next_addr_c
);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [BASE_W-1:0]  r_row_base;
  logic               w_col_last;
  logic               w_row_last;

  assign w_col_last = (r_col == i_wid - COORD_W'(1));
  assign w_row_last = (r_row == i_hgt - COORD_W'(1));
  assign o_last_c   = w_col_last & w_row_last;

  // End of a row jumps to the next row base; otherwise step one pixel right
  assign o_next_addr_c = w_col_last ? ADDR_WIDTH'(r_row_base + BASE_W'(SCREEN_WIDTH))
                                    : ADDR_WIDTH'(r_row_base + BASE_W'(r_col) + BASE_W'(1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= i_base;
    end else if (i_adv) begin
      if (w_col_last) begin
        r_col      <= '0;
        r_row      <= r_row + COORD_W'(1);
        r_row_base <= r_row_base + BASE_W'(SCREEN_WIDTH);
      end else begin
        r_col <= r_col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/fill_rect_data_gen.sv
// Fill-rect pixel generator: latches a decoded rectangle command and streams one
// {address, RGB444} write per rts/rtr transfer toward the memory arbiter.
module fill_rect_data_gen
  import fill_rect_data_gen_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [COORD_W-1:0]    cmd_data_origx,
  input  logic [COORD_W-1:0]    cmd_data_origy,
  input  logic [COORD_W-1:0]    cmd_data_wid,
  input  logic [COORD_W-1:0]    cmd_data_hgt,
  input  logic [CHAN_W-1:0]     cmd_data_rval,
  input  logic [CHAN_W-1:0]     cmd_data_gval,
  input  logic [CHAN_W-1:0]     cmd_data_bval,
  input  logic                  addr_start_strobe,
  output logic                  data_gen_is_idle,
  output logic                  arb_rts,
  input  logic                  arb_rtr,
  output logic [ADDR_WIDTH-1:0] arb_addr,
  output logic [PIX_W-1:0]      arb_data,
  output logic                  rect_done
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [COORD_W-1:0]    r_wid;
  logic [COORD_W-1:0]    r_hgt;
  logic                  r_arb_rts;
  logic [ADDR_WIDTH-1:0] r_arb_addr;
  logic [PIX_W-1:0]      r_arb_data;
  logic                  r_rect_done;

  logic                  w_xfc;
  logic                  w_load;
  logic                  w_rts_nxt;
  logic                  w_done_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [PIX_W-1:0]      w_data_nxt;
  logic [BASE_W-1:0]     w_start_base;
  rgb444_t               w_rgb;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_xfc        = r_arb_rts & arb_rtr;
  assign w_start_base = lin_addr(cmd_data_origx, cmd_data_origy, SCREEN_WIDTH);
  assign w_rgb        = '{r: cmd_data_rval, g: cmd_data_gval, b: cmd_data_bval};

  fill_rect_raster_counter #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_raster (
    .clk           (clk),
    .rst_          (rst_),
    .i_load        (w_load),
    .i_base        (w_start_base),
    .i_wid         (r_wid),
    .i_hgt         (r_hgt),
    .i_adv         (w_xfc),
    .o_last_c      (w_last),
    .o_next_addr_c (w_next_addr)
  );

  // Next-state and next-output decode; fields are sampled in SETUP, not at the strobe
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rts_nxt   = r_arb_rts;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = r_arb_addr;
    w_data_nxt  = r_arb_data;
    case (r_state)
      ST_IDLE: begin
        if (addr_start_strobe) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_load     = 1'b1;
        w_data_nxt = w_rgb;
        if ((cmd_data_wid == '0) || (cmd_data_hgt == '0)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
          w_rts_nxt   = 1'b1;
          w_addr_nxt  = ADDR_WIDTH'(w_start_base);
        end
      end
      ST_RUN: begin
        if (w_xfc) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_rts_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt = w_next_addr;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= ST_IDLE;
      r_wid       <= '0;
      r_hgt       <= '0;
      r_arb_rts   <= 1'b0;
      r_arb_addr  <= '0;
      r_arb_data  <= '0;
      r_rect_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_arb_rts   <= w_rts_nxt;
      r_arb_addr  <= w_addr_nxt;
      r_arb_data  <= w_data_nxt;
      r_rect_done <= w_done_nxt;
      if (w_load) begin
        r_wid <= cmd_data_wid;
        r_hgt <= cmd_data_hgt;
      end
    end
  end

  assign data_gen_is_idle = (r_state == ST_IDLE);
  assign arb_rts          = r_arb_rts;
  assign arb_addr         = r_arb_addr;
  assign arb_data         = r_arb_data;
  assign rect_done        = r_rect_done;

endmodule
